// File: rtl/encode8.sv
// rtl/encode8.sv - posit<8,0> encoder: two-stage pipeline with valid/ready handshakes
//
// Builds an 8-bit posit (es=0) from sign, regime value k and an MSB-aligned
// fraction (hidden 1 implied). Stage 1 lays out regime + fraction and derives
// the 7-bit body with guard and sticky bits. Stage 2 rounds, saturates and
// applies the sign.
//
// Build option: define ENCODE8_ROUND_EN for round-to-nearest-even. Otherwise
// the body is truncated.
//
// Ports:
//   clk        clock; all state updates on its rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input fields valid
//   in_ready   encoder accepts input this cycle
//   in_s       sign, 1 = negative
//   in_k       regime value k, two's complement (scale 2^k)
//   in_f       fraction after hidden 1, bit7 = 2^-1
//   in_zero    encode zero; overrides all other fields
//   in_nar     encode NaR; overrides all fields, including in_zero
//   out_valid  out_p8 valid
//   out_ready  consumer accepts out_p8
//   out_p8     encoded posit<8,0>
//   sat_cnt    number of clamped or round-saturated outputs; sticks at 0xFF
//   sat_clr    synchronous clear of sat_cnt; wins over an increment

module encode8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_s,
    input  logic [7:0] in_k,
    input  logic [7:0] in_f,
    input  logic       in_zero,
    input  logic       in_nar,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_p8,
    output logic [7:0] sat_cnt,
    input  logic       sat_clr
);

`ifdef ENCODE8_ROUND_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    // Stage 1 registers
    logic       s1_valid;
    logic [6:0] s1_body;
    logic       s1_guard;
    logic       s1_sticky;
    logic       s1_sign;
    logic       s1_clamp;
    logic       s1_zero;
    logic       s1_nar;

    // Stage 2 registers
    logic       s2_valid;
    logic [7:0] s2_p8;
    logic       s2_sat;

    logic s2_en;

    assign s2_en     = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_en;
    assign out_valid = s2_valid;
    assign out_p8    = s2_p8;

    // ---------------- Stage 1: regime / fraction layout ----------------
    logic signed [7:0]  k_s;
    logic               k_hi;
    logic               k_lo;
    logic [2:0]         pos_sh;
    logic [2:0]         neg_sh;
    logic signed [23:0] pos_seed;
    logic [23:0]        neg_seed;
    logic [23:0]        vec;
    logic [6:0]         body_c;
    logic               guard_c;
    logic               sticky_c;

    assign k_s  = in_k;
    assign k_hi = k_s > 8'sd6;
    assign k_lo = k_s < -8'sd6;

    // k >= 0: seed "10" then the fraction; an arithmetic right shift by k
    // replicates the leading 1, giving k+1 ones followed by the terminating 0.
    // k < 0: seed "01"; a logical shift by -k-1 (= ~k) gives -k zeros then 1.
    assign pos_sh   = in_k[2:0];
    assign neg_sh   = ~in_k[2:0];
    assign pos_seed = {2'b10, in_f, 14'd0};
    assign neg_seed = {2'b01, in_f, 14'd0};

    always_comb begin
        vec = '0;
        if (in_k[7]) begin
            vec = neg_seed >> neg_sh;
        end else begin
            vec = pos_seed >>> pos_sh;
        end
    end

    // In the truncating build guard and sticky are held at zero, so the
    // stage-2 rounding term is always zero and everything else is shared.
    always_comb begin
        body_c   = vec[23:17];
        guard_c  = ROUND_EN & vec[16];
        sticky_c = ROUND_EN & (|vec[15:0]);
        if (k_hi) begin
            body_c   = 7'h7F;
            guard_c  = 1'b0;
            sticky_c = 1'b0;
        end else if (k_lo) begin
            body_c   = 7'h01;
            guard_c  = 1'b0;
            sticky_c = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_body   <= '0;
            s1_guard  <= 1'b0;
            s1_sticky <= 1'b0;
            s1_sign   <= 1'b0;
            s1_clamp  <= 1'b0;
            s1_zero   <= 1'b0;
            s1_nar    <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_body   <= body_c;
                s1_guard  <= guard_c;
                s1_sticky <= sticky_c;
                s1_sign   <= in_s;
                s1_clamp  <= k_hi || k_lo;
                s1_zero   <= in_zero && !in_nar;
                s1_nar    <= in_nar;
            end
        end
    end

    // ---------------- Stage 2: round, saturate, sign ----------------
    logic       round_up;
    logic [7:0] sum_c;
    logic [6:0] rbody_c;
    logic       rnd_sat;
    logic [7:0] mag_c;
    logic [7:0] p8_c;
    logic       sat_c;

    assign round_up = s1_guard && (s1_body[0] || s1_sticky);
    assign sum_c    = {1'b0, s1_body} + {7'd0, round_up};
    // Rounding that lands on (or past) maxpos counts as saturation.
    assign rnd_sat  = round_up && (sum_c >= 8'h7F);

    always_comb begin
        rbody_c = sum_c[6:0];
        if (sum_c[7]) begin
            rbody_c = 7'h7F;
        end else if (sum_c[6:0] == 7'h00) begin
            rbody_c = 7'h01;
        end
    end

    assign mag_c = {1'b0, rbody_c};

    always_comb begin
        p8_c  = s1_sign ? (~mag_c + 8'd1) : mag_c;
        sat_c = s1_clamp || rnd_sat;
        if (s1_nar) begin
            p8_c  = 8'h80;
            sat_c = 1'b0;
        end else if (s1_zero) begin
            p8_c  = 8'h00;
            sat_c = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_p8    <= 8'h00;
            s2_sat   <= 1'b0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_p8  <= p8_c;
                s2_sat <= sat_c;
            end
        end
    end

    // ---------------- Saturation counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= 8'h00;
        end else if (sat_clr) begin
            sat_cnt <= 8'h00;
        end else if (s2_valid && out_ready && s2_sat && (sat_cnt != 8'hFF)) begin
            sat_cnt <= sat_cnt + 8'd1;
        end
    end

endmodule

// File: doc/encode8.md
ENCODE8 -- requirements
Module: encode8

Interface
- REQ-001 SHALL implement: one clock; reset is asynchronous and active-low.
- REQ-002 SHALL have port clk, input, 1 bit: sole clock; all state updates on rising edge.
- REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
- REQ-004 SHALL have port in_valid, input, 1 bit: input fields valid.
- REQ-005 SHALL have port in_ready, output, 1 bit: encoder accepts input this cycle.
- REQ-006 SHALL have port in_s, input, 1 bit: sign, 1 = negative.
- REQ-007 SHALL have port in_k, input, 8 bits signed: regime value k (es=0, scale 2^k).
- REQ-008 SHALL have port in_f, input, 8 bits: fraction after hidden 1, MSB-aligned (bit7 = 2^-1).
- REQ-009 SHALL have port in_zero, input, 1 bit: encode zero; overrides all other fields.
- REQ-010 SHALL have port in_nar, input, 1 bit: encode NaR; overrides all fields, including in_zero.
- REQ-011 SHALL have port out_valid, output, 1 bit: out_p8 valid.
- REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts out_p8.
- REQ-013 SHALL have port out_p8, output, 8 bits: encoded posit<8,0>.
- REQ-014 SHALL have port sat_cnt, output, 8 bits: count of clamped encodings.
- REQ-015 SHALL have port sat_clr, input, 1 bit: synchronous clear of sat_cnt.

Function
- REQ-016 SHALL fire transfers on valid&ready at each port; out_p8 SHALL hold stable while out_valid=1 and out_ready=0.
- REQ-017 SHALL use a 2-stage pipeline. S1 builds regime, fraction, guard and sticky. S2 rounds, clamps and applies the sign.
- REQ-018 SHALL present out_valid two cycles after the accepting edge when out_ready=1 throughout; full throughput SHALL be 1 per cycle.
- REQ-019 SHALL drive in_ready = !s1_valid | (!s2_valid | out_ready); each stage SHALL advance only when its downstream is empty or draining, with no bubble insertion or data loss.
- REQ-020 SHALL form the regime as follows. For k>=0: k+1 ones then a 0. For k<0: -k zeros then a 1. Regime plus fraction SHALL be truncated to the 7-bit body.
- REQ-021 SHALL clamp k>6 to body 0x7F and k<-6 to body 0x01, and SHALL never produce zero from a nonzero input.
- REQ-022 SHALL compute guard as the first discarded fraction bit and sticky as the OR of the remaining discarded bits.
- REQ-023 SHALL, after rounding, saturate the body at 0x7F and floor it at 0x01.
- REQ-024 SHALL output the body when s=0 and the two's complement of {0,body} when s=1.
- REQ-025 SHALL output out_p8=0x00 for zero and 0x80 for NaR, ignoring sign; neither SHALL count as clamped.
- REQ-026 SHALL increment sat_cnt by 1 per output handshake whose result was clamped (REQ-021) or saturated by rounding (REQ-023), and SHALL hold at 0xFF.
- REQ-027 SHALL give sat_clr priority when it coincides with an increment: the result SHALL be 0.

Reset
- REQ-028 SHALL, while rst_n=0, force out_valid=0, out_p8=0x00, sat_cnt=0 and both stage-valid flags to 0.
- REQ-029 SHALL discard in-flight data on reset assertion mid-operation; no output handshake SHALL follow for it.
- REQ-030 SHALL assert in_ready in the first cycle after rst_n deasserts.

Configuration
- REQ-031 SHALL, when macro ENCODE8_ROUND_EN is defined, round to nearest even: round up iff guard&(lsb|sticky).
- REQ-032 SHALL, when ENCODE8_ROUND_EN is undefined, truncate (guard and sticky ignored); all other behaviour SHALL be identical.

Verification
- REQ-033 SHALL cover: s=0,k=0,f=0x00 -> 0x40; s=1 same -> 0xC0; k=-1,f=0x00 -> 0x20; k=1,f=0x80 -> 0x68.
- REQ-034 SHALL cover: k=9 -> 0x7F with sat_cnt+1; k=-9,s=1 -> 0xFF with sat_cnt+1; in_zero=1 -> 0x00; in_nar=1,in_zero=1 -> 0x80; neither of the last two SHALL change the count.
- REQ-035 SHALL cover, with ENCODE8_ROUND_EN defined: k=5,f=0x80 -> 0x7E (tie to even); k=5,f=0xC0 -> 0x7F with sat_cnt+1. With it undefined: both -> 0x7E.
- REQ-036 SHALL cover: stream 4 inputs with out_ready held 0 for 3 cycles -> in_ready falls after 2 accepts, out_p8 stays stable, all 4 outputs arrive in order, none lost.
- REQ-037 SHALL cover: sat_cnt=0xFF plus a clamped output -> stays 0xFF; sat_clr coincident with an increment -> 0.
- REQ-038 SHALL cover: rst_n pulsed low with 2 items in flight -> out_valid=0 immediately, no stale output afterward, in_ready=1 the next cycle.
